// File: rtl/typing_pkg.sv
// Shared types and constants for the keypad typing game.
// Holds the FSM state encoding, key width, BCD limits and the BCD incrementer.
package typing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PLAY,
        DONE
    } state_t;

    localparam int                KEY_W             = 4;
    localparam logic [3:0]        BCD_MAX           = 4'd9;
    localparam logic [KEY_W-1:0]  START_KEY_DEFAULT = 4'hA;

    // Four-digit BCD increment with ripple carry; 9999 is a fixed point.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        if (value == 16'h9999) begin
            return value;
        end
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (result[i*4 +: 4] == BCD_MAX) begin
                    result[i*4 +: 4] = 4'd0;
                end else begin
                    result[i*4 +: 4] = result[i*4 +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: accepts a level change only after it has been stable for
// DEBOUNCE_CYCLES clocks and emits a one-cycle event on each accepted press.
module key_debounce
    import typing_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             button_pressed,
    input  logic [KEY_W-1:0] dec_out,
    output logic             key_valid,
    output logic [KEY_W-1:0] key_code
);

    localparam int             CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             level;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            level     <= 1'b0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
        end else begin
            key_valid <= 1'b0;
            if (button_pressed == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= button_pressed;
                cnt   <= '0;
                if (button_pressed) begin
                    key_valid <= 1'b1;
                    key_code  <= dec_out;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/typing_game_ctrl.sv
// Typing game sequencer: target latching, typing progress, game timer,
// BCD score and miss counter, driving a 4-digit seven-segment display.
module typing_game_ctrl
    import typing_pkg::*;
#(
    parameter int               GAME_SECONDS    = 30,
    parameter int               DEBOUNCE_CYCLES = 1_000_000,
    parameter logic [KEY_W-1:0] START_KEY       = START_KEY_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             one_hz_tick,
    input  logic             button_pressed,
    input  logic [KEY_W-1:0] dec_out,
    input  logic [KEY_W-1:0] rand_one,
    input  logic [KEY_W-1:0] rand_two,
    input  logic [KEY_W-1:0] rand_three,
    input  logic [KEY_W-1:0] rand_four,
    output logic [3:0]       digit_one,
    output logic [3:0]       digit_two,
    output logic [3:0]       digit_three,
    output logic [3:0]       digit_four,
    output logic             one_en,
    output logic             two_en,
    output logic             three_en,
    output logic             four_en,
    output logic [6:0]       seconds_left,
    output logic [7:0]       miss_count,
    output logic             game_over
);

    state_t                  state, next_state;
    logic                    key_valid;
    logic [KEY_W-1:0]        key_code;
    logic [3:0][KEY_W-1:0]   target;
    logic [3:0][3:0]         digit;
    logic [3:0]              en;
    logic [1:0]              pos;
    logic [15:0]             score, score_next;
    logic                    restart;
    logic                    key_hit, word_done, time_up, start_hit;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk            (clk),
        .reset          (reset),
        .button_pressed (button_pressed),
        .dec_out        (dec_out),
        .key_valid      (key_valid),
        .key_code       (key_code)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every signal written here gets a default first, otherwise any
    // path that skips an assignment infers a latch.
    always_comb begin
        next_state = state;
        key_hit    = key_valid && (key_code == target[pos]);
        word_done  = (state == PLAY) && key_hit && (pos == 2'd3);
        time_up    = (state == PLAY) && one_hz_tick && (seconds_left == 7'd1);
        start_hit  = key_valid && (key_code == START_KEY);
        score_next = word_done ? bcd_inc(score) : score;
        unique case (state)
            IDLE: if (start_hit) next_state = LOAD;
            LOAD: next_state = PLAY;
            PLAY: begin
                // Timer expiry wins over a word completion in the same cycle.
                if (time_up)        next_state = DONE;
                else if (word_done) next_state = LOAD;
            end
            DONE: if (start_hit) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            target       <= '0;
            digit        <= '0;
            en           <= '1;
            pos          <= 2'd0;
            score        <= '0;
            seconds_left <= 7'(GAME_SECONDS);
            miss_count   <= '0;
            game_over    <= 1'b0;
            restart      <= 1'b0;
        end else begin
            game_over <= (next_state == DONE);
            // In LOAD this tells a fresh game apart from a next word.
            restart   <= (state == IDLE) || (state == DONE);
            unique case (state)
                LOAD: begin
                    target <= {rand_four, rand_three, rand_two, rand_one};
                    digit  <= {rand_four, rand_three, rand_two, rand_one};
                    en     <= '1;
                    pos    <= 2'd0;
                    if (restart) begin
                        score        <= '0;
                        miss_count   <= '0;
                        seconds_left <= 7'(GAME_SECONDS);
                    end
                end
                PLAY: begin
                    score <= score_next;
                    if (one_hz_tick) seconds_left <= seconds_left - 7'd1;
                    if (key_valid) begin
                        if (key_hit) begin
                            en[pos] <= 1'b0;
                            pos     <= pos + 2'd1;
                        end else if (miss_count != 8'hFF) begin
                            miss_count <= miss_count + 8'd1;
                        end
                    end
                    if (next_state == DONE) begin
                        digit <= {score_next[3:0], score_next[7:4],
                                  score_next[11:8], score_next[15:12]};
                        en    <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign digit_one   = digit[0];
    assign digit_two   = digit[1];
    assign digit_three = digit[2];
    assign digit_four  = digit[3];
    assign one_en      = en[0];
    assign two_en      = en[1];
    assign three_en    = en[2];
    assign four_en     = en[3];

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Directed scoreboard bench for typing_game_ctrl with a short debounce
// and a 3-second game.
module tb_typing_game_ctrl;
    import typing_pkg::*;

    localparam int DEB = 4;
    localparam int GS  = 3;

    logic       clk = 1'b0;
    logic       reset, one_hz_tick, button_pressed;
    logic [3:0] dec_out, rand_one, rand_two, rand_three, rand_four;
    logic [3:0] digit_one, digit_two, digit_three, digit_four;
    logic       one_en, two_en, three_en, four_en;
    logic [6:0] seconds_left;
    logic [7:0] miss_count;
    logic       game_over;

    typing_game_ctrl #(.GAME_SECONDS(GS), .DEBOUNCE_CYCLES(DEB), .START_KEY(4'hA)) dut (
        .clk(clk), .reset(reset), .one_hz_tick(one_hz_tick),
        .button_pressed(button_pressed), .dec_out(dec_out),
        .rand_one(rand_one), .rand_two(rand_two), .rand_three(rand_three), .rand_four(rand_four),
        .digit_one(digit_one), .digit_two(digit_two), .digit_three(digit_three), .digit_four(digit_four),
        .one_en(one_en), .two_en(two_en), .three_en(three_en), .four_en(four_en),
        .seconds_left(seconds_left), .miss_count(miss_count), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] digits;
        logic [3:0]  en;
        logic [7:0]  miss;
        logic [6:0]  secs;
        logic        over;
        logic [15:0] score;
    } exp_t;

    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     kv_pulses;
    state_t st_a, st_b;

    // Reference model of the game
    state_t      m_state;
    logic [3:0]  m_target[4];
    int          m_pos, m_miss, m_score, m_secs;
    logic [3:0]  m_en;
    logic [15:0] m_digits;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_state  = IDLE;
        m_pos    = 0;
        m_en     = 4'hF;
        m_miss   = 0;
        m_score  = 0;
        m_secs   = GS;
        m_digits = 16'h0000;
    endfunction

    function automatic void model_load(input bit fresh);
        m_target[0] = rand_one;
        m_target[1] = rand_two;
        m_target[2] = rand_three;
        m_target[3] = rand_four;
        m_pos    = 0;
        m_en     = 4'hF;
        m_digits = {rand_one, rand_two, rand_three, rand_four};
        if (fresh) begin
            m_score = 0;
            m_miss  = 0;
            m_secs  = GS;
        end
        m_state = PLAY;
    endfunction

    function automatic void model_done();
        m_state  = DONE;
        m_digits = to_bcd(m_score);
        m_en     = 4'hF;
    endfunction

    function automatic void model_key(input logic [3:0] code, input bit tick);
        bit word = 1'b0;
        case (m_state)
            IDLE, DONE: if (code == 4'hA) model_load(1'b1);
            PLAY: begin
                if (code == m_target[m_pos]) begin
                    m_en[3 - m_pos] = 1'b0;
                    if (m_pos == 3) begin
                        word = 1'b1;
                        if (m_score < 9999) m_score++;
                    end else begin
                        m_pos++;
                    end
                end else if (m_miss < 255) begin
                    m_miss++;
                end
                if (tick) begin
                    m_secs--;
                    if (m_secs == 0) model_done();
                end
                if (m_state == PLAY && word) model_load(1'b0);
            end
            default: ;
        endcase
    endfunction

    function automatic void push_exp(input string tag);
        exp_t e;
        e.tag    = tag;
        e.digits = m_digits;
        e.en     = m_en;
        e.miss   = 8'(m_miss);
        e.secs   = 7'(m_secs);
        e.over   = (m_state == DONE);
        e.score  = to_bcd(m_score);
        sb.push_back(e);
    endfunction

    task automatic compare_out();
        exp_t e;
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ":digits"}, {digit_one, digit_two, digit_three, digit_four}, e.digits);
            check({e.tag, ":en"}, {one_en, two_en, three_en, four_en}, e.en);
            check({e.tag, ":miss"}, miss_count, e.miss);
            check({e.tag, ":secs"}, seconds_left, e.secs);
            check({e.tag, ":over"}, game_over, e.over);
            check({e.tag, ":score"}, dut.score, e.score);
        end
    endtask

    // Press and hold a key, optionally with a tick in the event cycle, then release.
    task automatic press(input logic [3:0] code, input int hold, input bit tick, input string tag);
        model_key(code, tick);
        push_exp(tag);
        @(negedge clk);
        dec_out        = code;
        button_pressed = 1'b1;
        kv_pulses      = 0;
        for (int i = 1; i <= hold; i++) begin
            @(negedge clk);
            if (dut.key_valid) kv_pulses++;
            if (i == DEB + 2) st_a = dut.state;
            if (i == DEB + 3) st_b = dut.state;
            one_hz_tick = tick && (i == DEB + 1);
        end
        button_pressed = 1'b0;
        for (int i = 0; i < DEB + 3; i++) begin
            @(negedge clk);
            if (dut.key_valid) kv_pulses++;
        end
        check({tag, ":events"}, kv_pulses, 1);
        compare_out();
    endtask

    task automatic tick_once(input string tag);
        if (m_state == PLAY) begin
            m_secs--;
            if (m_secs == 0) model_done();
        end
        push_exp(tag);
        @(negedge clk);
        one_hz_tick = 1'b1;
        @(negedge clk);
        one_hz_tick = 1'b0;
        compare_out();
    endtask

    initial begin
        reset = 1'b1;
        one_hz_tick = 1'b0;
        button_pressed = 1'b0;
        dec_out = 4'h0;
        {rand_one, rand_two, rand_three, rand_four} = 16'h371C;
        model_reset();
        repeat (3) @(negedge clk);
        push_exp("reset");
        compare_out();
        reset = 1'b0;

        press(4'hA, 20, 1'b0, "start");
        check("start_load", st_a, LOAD);
        check("start_play", st_b, PLAY);

        press(4'h3, DEB + 3, 1'b0, "key3");
        press(4'h7, DEB + 3, 1'b0, "key7");
        press(4'h5, DEB + 3, 1'b0, "key5_miss");
        press(4'h1, DEB + 3, 1'b0, "key1");
        {rand_one, rand_two, rand_three, rand_four} = 16'h2468;
        press(4'hC, DEB + 3, 1'b0, "word1");

        tick_once("tick1");
        tick_once("tick2");
        tick_once("tick3_done");
        tick_once("tick_in_done");

        press(4'hA, DEB + 3, 1'b0, "restart1");
        tick_once("r1_tick1");
        tick_once("r1_tick2");
        press(4'h2, DEB + 3, 1'b0, "r1_key2");
        press(4'h4, DEB + 3, 1'b0, "r1_key4");
        press(4'h6, DEB + 3, 1'b0, "r1_key6");
        press(4'h8, DEB + 3, 1'b1, "final_key_with_tick");

        press(4'hA, DEB + 3, 1'b0, "restart2");
        @(negedge clk);
        force dut.score = 16'h9999;
        repeat (2) @(negedge clk);
        release dut.score;
        m_score = 9999;
        press(4'h2, DEB + 3, 1'b0, "sat_key2");
        press(4'h4, DEB + 3, 1'b0, "sat_key4");
        press(4'h6, DEB + 3, 1'b0, "sat_key6");
        press(4'h8, DEB + 3, 1'b0, "sat_word");

        for (int n = 0; n < 256; n++) begin
            press(4'hF, DEB + 3, 1'b0, $sformatf("miss%0d", n));
        end
        check("miss_saturated", miss_count, 8'd255);

        push_exp("bounce");
        kv_pulses = 0;
        dec_out = 4'h2;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            button_pressed = (i < 2) || (i >= 4 && i < 6);
            if (dut.key_valid) kv_pulses++;
        end
        check("bounce_events", kv_pulses, 0);
        compare_out();

        @(negedge clk);
        dec_out = 4'h2;
        button_pressed = 1'b1;
        repeat (2) @(negedge clk);
        tick_once("pre_reset_tick");
        reset = 1'b1;
        model_reset();
        push_exp("mid_play_reset");
        @(negedge clk);
        compare_out();
        check("reset_state", dut.state, IDLE);
        check("reset_db_level", dut.u_debounce.level, 1'b0);
        check("reset_db_cnt", 32'(dut.u_debounce.cnt), 0);
        button_pressed = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/typing_game_ctrl.md
# typing_game_ctrl

Game sequencer for the keypad typing test. Sits between the keypad decoder, the random digit generator and the 4-digit seven-segment display driver. It debounces key presses, latches a 4-character target, tracks typing progress, counts down the game timer and keeps a BCD score. It then drives the display's four digit values and four digit enables.

## Interface
Parameters:
- `GAME_SECONDS`, default 30: game length in seconds (1..99).
- `DEBOUNCE_CYCLES`, default 1_000_000: number of `clk` cycles `button_pressed` must hold a stable level before a change is accepted (10 ms at 100 MHz).
- `START_KEY`, default 4'hA: key code that starts or restarts a game from IDLE or DONE.

Ports:
- `clk`, in, 1: system clock (100 MHz). One clock only; the reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high reset.
- `one_hz_tick`, in, 1: single-`clk`-cycle strobe, once per second.
- `button_pressed`, in, 1: raw key-held level from the decoder.
- `dec_out`, in, 4: decoder key code, valid while `button_pressed` is high.
- `rand_one`..`rand_four`, in, 4 each: free-running random digits.
- `digit_one`..`digit_four`, out, 4 each: values for the display.
- `one_en`..`four_en`, out, 1 each: digit enables for the display.
- `seconds_left`, out, 7: remaining game seconds.
- `miss_count`, out, 8: wrong keys pressed this game. Saturates at 255.
- `game_over`, out, 1: high while in DONE.

## Operation
- Debounce:
  - A key event is a 1-cycle `key_valid` pulse. It is produced when the debounced level rises, and carries `key_code`, which is `dec_out` sampled at that edge.
  - Holding a key produces exactly one event.
  - A release is recognised only after the raw low level has been stable for `DEBOUNCE_CYCLES`.
- States:
  - IDLE: all digits show 0, all enables on. A `START_KEY` event goes to LOAD.
  - LOAD (1 cycle):
    - latch `rand_one`..`rand_four` into the target and the digit outputs;
    - set all enables on and `pos` to 0;
    - if entered from IDLE or DONE, also clear the score, set `miss_count` to 0 and `seconds_left` to `GAME_SECONDS`;
    - go to PLAY. Any key event arriving during LOAD is dropped.
  - PLAY, on each key event:
    - If `key_code` equals target[`pos`], clear that digit's enable and increment `pos`.
    - If `pos` was 3, go to LOAD for a fresh target (this counts as a word completion) and increment the BCD score.
    - On a mismatch, `miss_count` += 1 (saturating) and `pos` is unchanged.
    - `START_KEY` has no special meaning in PLAY.
  - PLAY, timer: on each `one_hz_tick`, `seconds_left` -= 1. A tick that arrives while `seconds_left` is 1 makes it 0 and moves to DONE.
  - DONE:
    - digits show the score in BCD (`digit_one` = thousands … `digit_four` = ones), all enables on, `game_over` = 1;
    - score, `miss_count` and `seconds_left` hold their values;
    - a `START_KEY` event goes to LOAD.
- Score: 4 BCD digits with ripple carry, saturating at 9999.
- Simultaneous events:
  - A final-character key event in the same cycle as the expiring tick: the score increments and the next state is DONE, not LOAD.
  - `reset` overrides everything in every state, including mid-debounce.
  - `one_hz_tick` is ignored outside PLAY.

## Timing
- Reset values: state IDLE, all digits 0, all enables 1, `seconds_left` = `GAME_SECONDS`, `miss_count` 0, `game_over` 0, score 0, debouncer level 0 with its counter cleared.
- Key latency:
  - `key_valid` fires `DEBOUNCE_CYCLES` + 1 cycles after `button_pressed` first becomes stable high.
  - Outputs reflect the event in the next cycle.
- A tick in cycle N updates `seconds_left` in cycle N+1.
- LOAD lasts exactly one cycle, so new target digits appear 2 cycles after the completing key event.
- All outputs are registered.

## Structure
- Shared package `typing_pkg`:
  - the state enum (IDLE, LOAD, PLAY, DONE);
  - `KEY_W` = 4;
  - `BCD_MAX` = 4'd9;
  - the default `START_KEY`.
- Sub-module `key_debounce` (`clk`, `reset`, `button_pressed`, `dec_out` in; `key_valid`, `key_code` out), parameterised by `DEBOUNCE_CYCLES`.
- The FSM, BCD counter, timer and miss counter stay in the top.

## Test plan
Run with `DEBOUNCE_CYCLES` = 4 and `GAME_SECONDS` = 3.
- Reset, then hold `dec_out` = 4'hA high for 20 cycles → exactly one `key_valid`; state passes IDLE → LOAD → PLAY; digits equal the `rand_*` values sampled in LOAD; `seconds_left` = 3.
- Target 3,7,1,C; press 3, 7, 5, 1, C → enables go 0111, 0011, then 0011 held with `miss_count` = 1, then 0001; after C, score is 0001 and a new target loads with enables 1111.
- Apply 3 ticks in PLAY → `seconds_left` goes 3, 2, 1, 0; DONE with `game_over` = 1; digits show the BCD score.
- Final key event in the same cycle as the last tick → score increments and the state goes directly to DONE.
- Force score to 9999, complete a word → score stays 9999. Press 256 misses → `miss_count` = 255.
- Bounce `button_pressed` 1-0-1 with pulses of 2 cycles → no event. Assert `reset` mid-PLAY → all reset values the next cycle.
